read_control_v3: RTL

Parametrised DRAM-to-BRAM read sequencer for the DRAM ring buffer readout path. After an enable and a start-up delay, it walks a wrapping DRAM address window. At each address it issues a read request, counts returned data beats, and strobes each beat into the BRAM. It stalls while the BRAM reports full and retries on a read-valid timeout. It sits between the DRAM controller read port and the BRAM writer, under software control via `en`.

---
 rtl/read_control_v3_if.sv | 38 +++
 rtl/read_control_v3.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/read_control_v3_if.sv
`default_nettype none
// ============================================================================
// Module   : read_control_v3_if
// Brief    : Control/handshake bundle between the DRAM read sequencer, the
//            DRAM controller read port, the BRAM writer and software control.
// Revision : 1.0 - initial release
// ============================================================================
interface read_control_v3_if #(
  parameter int ADDR_W = 24
) ();
  logic              ce;
  logic              en;
  logic              rd_val;
  logic              bram_full;
  logic [ADDR_W-1:0] dram_addr;
  logic              en_read;
  logic              write_bram;
  logic [3:0]        state;
  logic [7:0]        counter;
  logic [15:0]       wrap_cnt;
  logic              timeout_err;
  logic              busy;

  // Sequencer side
  modport slave (
    input  ce, en, rd_val, bram_full,
    output dram_addr, en_read, write_bram, state, counter, wrap_cnt,
           timeout_err, busy
  );

  // Environment side (DRAM port, BRAM writer, software)
  modport master (
    output ce, en, rd_val, bram_full,
    input  dram_addr, en_read, write_bram, state, counter, wrap_cnt,
           timeout_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/read_control_v3.sv
`default_nettype none
// ============================================================================
// Module   : read_control_v3
// Brief    : DRAM-to-BRAM read sequencer. Walks a wrapping DRAM address window,
//            issues one read request per burst, strobes returned beats into
//            the BRAM, stalls on BRAM full and retries on read-valid timeout.
// Revision : 1.0 - initial release
// ============================================================================
module read_control_v3 #(
  parameter int          ADDR_W    = 24,
  parameter int unsigned ADDR_BASE = 0,
  parameter int unsigned ADDR_END  = 32'd16777216,
  parameter int unsigned BURST_LEN = 1,
  parameter int unsigned REQ_HOLD  = 2,
  parameter int unsigned INIT_WAIT = 128,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  read_control_v3_if.slave   bus
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_ARM      = 4'd1,
    S_INIT     = 4'd2,
    S_REQ      = 4'd3,
    S_WAIT_VAL = 4'd4,
    S_CHECK    = 4'd5,
    S_HOLD     = 4'd6,
    S_ADVANCE  = 4'd7
  } state_t;

  // Address math is one bit wider so ADDR_END = 2^ADDR_W compares cleanly.
  localparam logic [ADDR_W:0]   END_X     = ADDR_END[ADDR_W:0];
  localparam logic [ADDR_W:0]   INC_X     = BURST_LEN[ADDR_W:0];
  localparam logic [ADDR_W-1:0] BASE_X    = ADDR_BASE[ADDR_W-1:0];
  localparam logic [7:0]        INIT_LAST = 8'(INIT_WAIT);
  localparam logic [7:0]        BURST_X   = 8'(BURST_LEN);
  localparam logic [3:0]        HOLD_LAST = 4'(REQ_HOLD - 1);
  localparam logic [15:0]       TMO_LAST  = 16'(TIMEOUT - 1);

  state_t            state_q;
  logic [7:0]        init_cnt_q;
  logic [3:0]        hold_cnt_q;
  logic [7:0]        beat_cnt_q;
  logic [15:0]       tmo_cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wrap_q;
  logic              terr_q;
  logic              init_done_q;
  logic              wb_q;

  logic [ADDR_W:0]   sum_d;
  logic              wrap_hit_d;
  logic [ADDR_W-1:0] addr_next_d;
  logic [7:0]        beat_inc_d;

  // Next burst address and the window-wrap decision used in ADVANCE.
  always_comb begin
    sum_d       = {1'b0, addr_q} + INC_X;
    wrap_hit_d  = (sum_d == END_X);
    addr_next_d = wrap_hit_d ? BASE_X : sum_d[ADDR_W-1:0];
    beat_inc_d  = beat_cnt_q + 8'd1;
  end

  // Sequencer FSM with all counters, address, flags and the beat strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      init_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      beat_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      addr_q      <= BASE_X;
      wrap_q      <= '0;
      terr_q      <= 1'b0;
      init_done_q <= 1'b0;
      wb_q        <= 1'b0;
    end else if (bus.ce) begin
      wb_q       <= 1'b0;
      hold_cnt_q <= '0;
      case (state_q)
        S_IDLE: state_q <= S_ARM;
        S_ARM: begin
          if (bus.en) begin
            if (init_done_q) begin
              state_q <= S_REQ;
            end else begin
              state_q    <= S_INIT;
              init_cnt_q <= '0;
            end
          end
        end
        S_INIT: begin
          if (init_cnt_q == INIT_LAST) begin
            init_done_q <= 1'b1;
            state_q     <= S_REQ;
          end else begin
            init_cnt_q <= init_cnt_q + 8'd1;
          end
        end
        S_REQ: begin
          // Beat and timeout counters start every attempt from zero.
          beat_cnt_q <= '0;
          tmo_cnt_q  <= '0;
          if (hold_cnt_q == HOLD_LAST) begin
            state_q <= S_WAIT_VAL;
          end else begin
            hold_cnt_q <= hold_cnt_q + 4'd1;
          end
        end
        S_WAIT_VAL: begin
          if (bus.rd_val) begin
            wb_q       <= 1'b1;
            beat_cnt_q <= beat_inc_d;
            tmo_cnt_q  <= '0;
            if (beat_inc_d == BURST_X) begin
              state_q <= S_CHECK;
            end
          end else if (tmo_cnt_q == TMO_LAST) begin
            // Retry the same address; beats already written get rewritten.
            terr_q  <= 1'b1;
            state_q <= S_REQ;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
          end
        end
        S_CHECK: state_q <= bus.bram_full ? S_HOLD : S_ADVANCE;
        S_HOLD: begin
          if (!bus.bram_full) begin
            state_q <= S_ADVANCE;
          end
        end
        S_ADVANCE: begin
          addr_q <= addr_next_d;
          if (wrap_hit_d && (wrap_q != 16'hFFFF)) begin
            wrap_q <= wrap_q + 16'd1;
          end
          state_q <= bus.en ? S_REQ : S_ARM;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.state       = state_q;
  assign bus.dram_addr   = addr_q;
  assign bus.en_read     = (state_q == S_REQ);
  assign bus.write_bram  = wb_q;
  assign bus.wrap_cnt    = wrap_q;
  assign bus.timeout_err = terr_q;
  assign bus.busy        = (state_q != S_IDLE) && (state_q != S_ARM);
  assign bus.counter     = (state_q == S_INIT)     ? init_cnt_q :
                           (state_q == S_WAIT_VAL) ? beat_cnt_q : 8'd0;

endmodule
`default_nettype wire
